// File: rtl/attn_head_scheduler.sv
// attn_head_scheduler: sequences one multi-head attention layer over a shared
// compute engine. Commands go out one at a time over a valid/ready port and
// the next command is chosen only after the engine's completion pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no layer in progress; waiting for start
// ISSUE  | cmd_valid high, command fields held until cmd_ready
// WAIT   | command accepted, waiting for eng_done
// DONE   | final command completed; one-cycle done pulse
module attn_head_scheduler #(
    parameter int SEQ    = 16,
    parameter int HEADS  = 8,
    parameter int HEAD_W = (HEADS > 1) ? $clog2(HEADS) : 1,
    parameter int ROW_W  = (SEQ > 1) ? $clog2(SEQ) : 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [2:0]        cmd_op,
    output logic [HEAD_W-1:0] cmd_head,
    output logic [ROW_W-1:0]  cmd_row,
    input  logic              eng_done,
    output logic [CNT_W-1:0]  cmd_cnt,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] OP_PROJ_QKV = 3'd0;
    localparam logic [2:0] OP_SCORE    = 3'd1;
    localparam logic [2:0] OP_SOFTMAX  = 3'd2;
    localparam logic [2:0] OP_AV       = 3'd3;
    localparam logic [2:0] OP_OUT_PROJ = 3'd4;

    localparam logic [HEAD_W-1:0] HEAD_LAST = HEAD_W'(HEADS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(SEQ - 1);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [HEAD_W-1:0] head_q, head_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // Next-state, command selection, progress counter and error flag.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        head_d  = head_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    op_d    = OP_PROJ_QKV;
                    head_d  = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = S_ISSUE;
                    case (op_q)
                        OP_PROJ_QKV: begin
                            op_d  = OP_SCORE;
                            row_d = '0;
                        end
                        OP_SCORE:   op_d = OP_SOFTMAX;
                        OP_SOFTMAX: op_d = OP_AV;
                        OP_AV: begin
                            if (row_q != ROW_LAST) begin
                                op_d  = OP_SCORE;
                                row_d = row_q + ROW_W'(1);
                            end else if (head_q != HEAD_LAST) begin
                                op_d   = OP_PROJ_QKV;
                                head_d = head_q + HEAD_W'(1);
                                row_d  = '0;
                            end else begin
                                op_d   = OP_OUT_PROJ;
                                head_d = '0;
                                row_d  = '0;
                            end
                        end
                        OP_OUT_PROJ: begin
                            if (row_q != ROW_LAST) begin
                                row_d = row_q + ROW_W'(1);
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats start and eng_done; the counter and fields keep their values.
        if (abort) begin
            state_d = S_IDLE;
            op_d    = op_q;
            head_d  = head_q;
            row_d   = row_q;
            cnt_d   = cnt_q;
            err_d   = err_q;
        end

        // A completion pulse is only legal while a command is outstanding.
        if (eng_done && (state_q != S_WAIT)) begin
            err_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_PROJ_QKV;
            head_q  <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            head_q  <= head_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign cmd_valid = (state_q == S_ISSUE);
    assign cmd_op    = op_q;
    assign cmd_head  = head_q;
    assign cmd_row   = row_q;
    assign cmd_cnt   = cnt_q;
    assign err       = err_q;

endmodule
